apb_cmd_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single 64-bit APB command port (`cmd`/`cmd_vld`) of the APB master among `REQ_NUM` requesters. It screens each command for legality before issuing it. It then holds the command stable until the transfer completes, which it detects by monitoring the APB bus, and returns the read data, error status and timeout status to the granted requester. The block sits between the system-side requesters and the APB master.

---
 rtl/apb_cmd_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_apb_cmd_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_arbiter.sv
// apb_cmd_arbiter
// Shares the single APB master command port among REQ_NUM requesters.
// A round-robin pick is made in IDLE, the command is screened for legality,
// issued and held on cmd/cmd_vld until the bus monitor sees the transfer
// complete (or the timeout expires), and the result is returned to the owner.
//
// Ports
//   pclk, presetn       clock, asynchronous active-low reset
//   req_vld / req_cmd   per-requester command valid and command slices
//   req_rdy             one-cycle accept pulse to the granted requester
//   rsp_vld             one-cycle response pulse to the owning requester
//   rsp_rdata/err/tmo   response payload, valid only while rsp_vld is high
//   cmd / cmd_vld       command to the APB master
//   mon_*               APB bus monitor (psel OR, penable, pready, pslverr, prdata)
//   busy                FSM not in IDLE
//   grant_id            current or last grantee
//
// Handshakes: a requester raises req_vld with a stable req_cmd and holds both
// until it sees req_rdy for its own bit; dropping req_vld earlier withdraws
// the request. rsp_vld is a single-cycle pulse with no back-pressure.
// cmd_vld stays high with cmd stable until the monitored transfer completes.
//
// All outputs are registered: the comb output process computes next values
// from the current state and inputs, and they are captured on the same edge
// as the state transition.
module apb_cmd_arbiter #(
    parameter int CMD_WIDTH  = 64,
    parameter int DATA_WIDTH = 32,
    parameter int REQ_NUM    = 4,
    parameter int TIMEOUT    = 255,
    parameter int GAP        = 2
) (
    input  logic                         pclk,
    input  logic                         presetn,
    input  logic [REQ_NUM-1:0]           req_vld,
    input  logic [REQ_NUM*CMD_WIDTH-1:0] req_cmd,
    output logic [REQ_NUM-1:0]           req_rdy,
    output logic [REQ_NUM-1:0]           rsp_vld,
    output logic [DATA_WIDTH-1:0]        rsp_rdata,
    output logic                         rsp_err,
    output logic                         rsp_tmo,
    output logic [CMD_WIDTH-1:0]         cmd,
    output logic                         cmd_vld,
    input  logic                         mon_psel,
    input  logic                         mon_penable,
    input  logic                         mon_pready,
    input  logic                         mon_pslverr,
    input  logic [DATA_WIDTH-1:0]        mon_prdata,
    output logic                         busy,
    output logic [$clog2(REQ_NUM)-1:0]   grant_id
);
    localparam int IW = $clog2(REQ_NUM);
    // A zero TIMEOUT disables the counter; keep one bit so the width is legal.
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [CMD_WIDTH-1:0] cmd_slot [REQ_NUM];
    logic [CMD_WIDTH-1:0] sel_cmd, cmd_q;
    logic [IW-1:0]        rr_ptr, rr_cand, sel, rr_nxt;
    logic                 any_req, sel_legal, illegal_q;
    logic                 done, tmo_hit;
    logic [TW-1:0]        tmo_cnt;
    logic [GW-1:0]        gap_cnt;

    logic [REQ_NUM-1:0]    req_rdy_d, rsp_vld_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_d;
    logic                  rsp_err_d, rsp_tmo_d, cmd_vld_d, busy_d;

    for (genvar g = 0; g < REQ_NUM; g++) begin : g_slot
        assign cmd_slot[g] = req_cmd[g*CMD_WIDTH +: CMD_WIDTH];
    end

    // Round-robin pick: scan from rr_ptr downwards in priority so the
    // closest requester at or after rr_ptr wins.
    always_comb begin
        sel     = '0;
        rr_cand = '0;
        for (int i = REQ_NUM - 1; i >= 0; i--) begin
            rr_cand = IW'((int'(rr_ptr) + i) % REQ_NUM);
            if (req_vld[rr_cand]) sel = rr_cand;
        end
    end

    assign any_req   = |req_vld;
    assign sel_cmd   = cmd_slot[sel];
    assign rr_nxt    = (sel == IW'(REQ_NUM - 1)) ? '0 : sel + 1'b1;
    assign sel_legal = (sel_cmd[47:46] == 2'b01) &&
                       ((sel_cmd[55:48] == 8'h00) || (sel_cmd[55:48] == 8'h01));
    assign done      = mon_psel & mon_penable & mon_pready;
    assign tmo_hit   = (TIMEOUT != 0) && (tmo_cnt == TW'(TIMEOUT));

    // State register
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (any_req) state_nxt = sel_legal ? S_ISSUE : S_RESP;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (done || tmo_hit) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_GAP;
            S_GAP:   if (gap_cnt == GW'(GAP - 1)) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic (next values of the registered outputs)
    always_comb begin
        req_rdy_d   = '0;
        rsp_vld_d   = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        rsp_tmo_d   = 1'b0;
        cmd_vld_d   = 1'b0;
        busy_d      = (state_nxt != S_IDLE);
        case (state)
            S_IDLE: if (any_req) req_rdy_d[sel] = 1'b1;
            S_ISSUE: cmd_vld_d = 1'b1;
            S_WAIT: begin
                if (done) begin
                    // Completion takes priority over a coincident timeout.
                    rsp_vld_d[grant_id] = 1'b1;
                    rsp_err_d           = mon_pslverr;
                    if (cmd_q[55:48] == 8'h00 && !mon_pslverr) rsp_rdata_d = mon_prdata;
                end else if (tmo_hit) begin
                    rsp_vld_d[grant_id] = 1'b1;
                    rsp_err_d           = 1'b1;
                    rsp_tmo_d           = 1'b1;
                end else begin
                    cmd_vld_d = 1'b1;
                end
            end
            // A completed transfer already pulsed rsp_vld on entry to RESP;
            // an illegal command, which skipped WAIT, is answered here.
            S_RESP: if (illegal_q) begin
                rsp_vld_d[grant_id] = 1'b1;
                rsp_err_d           = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            req_rdy   <= '0;
            rsp_vld   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            rsp_tmo   <= 1'b0;
            cmd       <= '0;
            cmd_vld   <= 1'b0;
            busy      <= 1'b0;
            grant_id  <= '0;
            rr_ptr    <= '0;
            cmd_q     <= '0;
            illegal_q <= 1'b0;
            tmo_cnt   <= '0;
            gap_cnt   <= '0;
        end else begin
            req_rdy   <= req_rdy_d;
            rsp_vld   <= rsp_vld_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            rsp_tmo   <= rsp_tmo_d;
            cmd_vld   <= cmd_vld_d;
            busy      <= busy_d;
            case (state)
                S_IDLE: if (any_req) begin
                    cmd_q     <= sel_cmd;
                    illegal_q <= !sel_legal;
                    grant_id  <= sel;
                    rr_ptr    <= rr_nxt;
                end
                S_ISSUE: begin
                    cmd     <= cmd_q;
                    tmo_cnt <= '0;
                end
                // Saturating count; stops at TIMEOUT rather than wrapping.
                S_WAIT: if (TIMEOUT != 0 && tmo_cnt != TW'(TIMEOUT)) tmo_cnt <= tmo_cnt + 1'b1;
                S_RESP: gap_cnt <= '0;
                S_GAP:  gap_cnt <= gap_cnt + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_cmd_arbiter.sv
// Directed bench for apb_cmd_arbiter (TIMEOUT=8, GAP=2, REQ_NUM=4).
// The bench plays the APB slave on the mon_* inputs and checks grants,
// issue timing, responses, the timeout path and mid-transfer reset.
module tb_apb_cmd_arbiter;
    localparam int CW = 64;
    localparam int DW = 32;
    localparam int RN = 4;

    localparam logic [63:0] RD0 = 64'h0F00_4004_0000_0000;
    localparam logic [63:0] RD1 = 64'h0F00_4010_0000_0000;
    localparam logic [63:0] ILL = 64'h0F01_0004_0000_0001;

    logic             pclk = 1'b0;
    logic             presetn;
    logic [RN-1:0]    req_vld;
    logic [RN*CW-1:0] req_cmd;
    logic [RN-1:0]    req_rdy, rsp_vld;
    logic [DW-1:0]    rsp_rdata;
    logic             rsp_err, rsp_tmo;
    logic [CW-1:0]    cmd;
    logic             cmd_vld;
    logic             mon_psel, mon_penable, mon_pready, mon_pslverr;
    logic [DW-1:0]    mon_prdata;
    logic             busy;
    logic [1:0]       grant_id;

    logic [CW-1:0] cmd_arr [RN];

    int n_chk  = 0;
    int n_fail = 0;

    for (genvar g = 0; g < RN; g++) begin : g_cmd
        assign req_cmd[g*CW +: CW] = cmd_arr[g];
    end

    apb_cmd_arbiter #(
        .CMD_WIDTH(CW), .DATA_WIDTH(DW), .REQ_NUM(RN), .TIMEOUT(8), .GAP(2)
    ) dut (
        .pclk(pclk), .presetn(presetn),
        .req_vld(req_vld), .req_cmd(req_cmd), .req_rdy(req_rdy),
        .rsp_vld(rsp_vld), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_tmo(rsp_tmo),
        .cmd(cmd), .cmd_vld(cmd_vld),
        .mon_psel(mon_psel), .mon_penable(mon_penable), .mon_pready(mon_pready),
        .mon_pslverr(mon_pslverr), .mon_prdata(mon_prdata),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] wr_cmd(input int i);
        wr_cmd = {8'h0F, 8'h01, 16'h4000 + 16'(i * 4), 32'hA000_0000 + 32'(i)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic mon_idle();
        mon_psel    = 1'b0;
        mon_penable = 1'b0;
        mon_pready  = 1'b0;
        mon_pslverr = 1'b0;
        mon_prdata  = '0;
    endtask

    task automatic do_reset();
        presetn = 1'b0;
        req_vld = '0;
        mon_idle();
        repeat (2) @(negedge pclk);
        check("rst_cmd", cmd, 64'h0);
        check("rst_cmd_vld", cmd_vld, 0);
        check("rst_req_rdy", req_rdy, 0);
        check("rst_rsp_vld", rsp_vld, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_tmo", rsp_tmo, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        presetn = 1'b1;
        @(negedge pclk);
    endtask

    // Raise one request, wait (bounded) for the accept pulse, then drop it.
    task automatic issue(input logic [1:0] id, input logic [63:0] c, input string tag);
        cmd_arr[id] = c;
        req_vld[id] = 1'b1;
        for (int t = 0; t < 20 && req_rdy == '0; t++) @(negedge pclk);
        check(tag, req_rdy, 64'(4'b0001 << id));
        req_vld[id] = 1'b0;
    endtask

    task automatic wait_cmd_vld(input string tag);
        for (int t = 0; t < 20 && !cmd_vld; t++) @(negedge pclk);
        check(tag, cmd_vld, 1);
    endtask

    // Called at the negedge where cmd_vld is first seen. Runs setup, then
    // 'waits' wait states, then completes; returns at the negedge right after
    // the completion edge, where the response is visible.
    task automatic apb_slave(input int waits, input logic [31:0] rdata, input logic err);
        mon_psel = 1'b1;
        @(negedge pclk);
        mon_penable = 1'b1;
        mon_pready  = (waits == 0);
        mon_prdata  = rdata;
        mon_pslverr = err;
        for (int i = 0; i < waits; i++) begin
            @(negedge pclk);
            check("cmd_vld_hold", cmd_vld, 1);
            if (i == waits - 1) mon_pready = 1'b1;
        end
        @(negedge pclk);
        mon_idle();
    endtask

    initial begin
        logic [3:0] got_rdy, exp_oh;
        logic [1:0] exp_id;
        int         low, extra, cnt, drop;
        logic       cmd_seen;

        for (int i = 0; i < RN; i++) cmd_arr[i] = '0;

        // ---- single legal read from req 0, 3 wait states
        do_reset();
        cmd_arr[0] = RD0;
        req_vld    = 4'b0001;
        @(negedge pclk);
        check("t1_req_rdy", req_rdy, 4'b0001);
        check("t1_busy", busy, 1);
        check("t1_grant_id", grant_id, 0);
        check("t1_cmd_vld_early", cmd_vld, 0);
        req_vld = '0;
        @(negedge pclk);
        check("t1_cmd_vld", cmd_vld, 1);
        check("t1_cmd", cmd, RD0);
        check("t1_req_rdy_pulse", req_rdy, 0);
        apb_slave(3, 32'hDEADBEEF, 1'b0);
        check("t1_rsp_vld", rsp_vld, 4'b0001);
        check("t1_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        check("t1_rsp_err", rsp_err, 0);
        check("t1_rsp_tmo", rsp_tmo, 0);
        check("t1_cmd_vld_fall", cmd_vld, 0);
        @(negedge pclk);
        check("t1_rsp_vld_pulse", rsp_vld, 0);

        // ---- all four requesters continuously asserted with writes
        do_reset();
        for (int i = 0; i < RN; i++) cmd_arr[i] = wr_cmd(i);
        req_vld = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_id  = 2'(k % 4);
            exp_oh  = 4'b0001 << exp_id;
            got_rdy = '0;
            low     = 0;
            extra   = 0;
            for (int t = 0; t < 20 && !cmd_vld; t++) begin
                if (req_rdy != '0) got_rdy = req_rdy;
                if (low > 0 && rsp_vld != '0) extra++;
                low++;
                @(negedge pclk);
            end
            check("t2_wait_cmd_vld", cmd_vld, 1);
            check("t2_grant", got_rdy, exp_oh);
            check("t2_grant_id", grant_id, exp_id);
            check("t2_cmd", cmd, wr_cmd(int'(exp_id)));
            check("t2_stray_rsp", extra, 0);
            if (k > 0) check("t2_gap_cycles", low, 5);
            apb_slave(1, 32'h5555_AAAA, 1'b0);
            check("t2_rsp_vld", rsp_vld, exp_oh);
            check("t2_rsp_rdata", rsp_rdata, 0);
            check("t2_rsp_err", rsp_err, 0);
            if (k == 4) req_vld = '0;
        end
        @(negedge pclk);
        check("t2_rsp_vld_pulse", rsp_vld, 0);
        repeat (3) @(negedge pclk);
        check("t2_idle", busy, 0);

        // ---- illegal command from req 2
        do_reset();
        cmd_arr[2] = ILL;
        req_vld    = 4'b0100;
        @(negedge pclk);
        check("t3_req_rdy", req_rdy, 4'b0100);
        check("t3_grant_id", grant_id, 2);
        req_vld = '0;
        @(negedge pclk);
        check("t3_rsp_vld", rsp_vld, 4'b0100);
        check("t3_rsp_err", rsp_err, 1);
        check("t3_rsp_tmo", rsp_tmo, 0);
        check("t3_rsp_rdata", rsp_rdata, 0);
        check("t3_cmd_vld", cmd_vld, 0);
        // rr_ptr is now 3: with everyone requesting, req 3 must win.
        for (int i = 0; i < RN; i++) cmd_arr[i] = wr_cmd(i);
        req_vld  = 4'b1111;
        cmd_seen = 1'b0;
        for (int t = 0; t < 20 && req_rdy == '0; t++) begin
            cmd_seen |= cmd_vld;
            @(negedge pclk);
        end
        req_vld = '0;
        check("t3_next_grant", req_rdy, 4'b1000);
        check("t3_no_issue", cmd_seen, 0);
        wait_cmd_vld("t3_wait_cmd_vld");
        check("t3_cmd", cmd, wr_cmd(3));
        apb_slave(0, 32'h0, 1'b0);
        check("t3_rsp_vld2", rsp_vld, 4'b1000);

        // ---- timeout: slave never raises pready
        issue(2'd1, RD1, "t4_grant");
        @(negedge pclk);
        check("t4_cmd_vld", cmd_vld, 1);
        mon_psel    = 1'b1;
        mon_penable = 1'b1;
        cnt  = 0;
        drop = 0;
        for (int t = 0; t < 20 && rsp_vld == '0; t++) begin
            @(negedge pclk);
            cnt++;
            if (rsp_vld == '0 && !cmd_vld) drop++;
        end
        mon_idle();
        check("t4_latency", cnt, 9);
        check("t4_cmd_vld_held", drop, 0);
        check("t4_rsp_vld", rsp_vld, 4'b0010);
        check("t4_rsp_err", rsp_err, 1);
        check("t4_rsp_tmo", rsp_tmo, 1);
        check("t4_rsp_rdata", rsp_rdata, 0);
        check("t4_cmd_vld_fall", cmd_vld, 0);
        repeat (3) @(negedge pclk);
        check("t4_idle", busy, 0);

        // ---- slave error on a write, then on a read
        issue(2'd0, wr_cmd(0), "t5_grant");
        wait_cmd_vld("t5_wait_cmd_vld");
        apb_slave(2, 32'h1234_5678, 1'b1);
        check("t5_rsp_vld", rsp_vld, 4'b0001);
        check("t5_rsp_err", rsp_err, 1);
        check("t5_rsp_tmo", rsp_tmo, 0);
        check("t5_rsp_rdata", rsp_rdata, 0);
        issue(2'd3, RD0, "t5b_grant");
        wait_cmd_vld("t5b_wait_cmd_vld");
        apb_slave(1, 32'hCAFE_F00D, 1'b1);
        check("t5b_rsp_vld", rsp_vld, 4'b1000);
        check("t5b_rsp_err", rsp_err, 1);
        check("t5b_rsp_rdata", rsp_rdata, 0);

        // ---- reset asserted during WAIT
        issue(2'd2, RD0, "t6_grant");
        wait_cmd_vld("t6_wait_cmd_vld");
        mon_psel = 1'b1;
        @(negedge pclk);
        mon_penable = 1'b1;
        @(negedge pclk);
        presetn = 1'b0;
        #1;
        check("t6_async_cmd_vld", cmd_vld, 0);
        check("t6_async_cmd", cmd, 64'h0);
        check("t6_async_busy", busy, 0);
        check("t6_async_grant_id", grant_id, 0);
        check("t6_async_rsp_vld", rsp_vld, 0);
        mon_idle();
        @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
        check("t6_no_rsp", rsp_vld, 0);
        check("t6_idle", busy, 0);
        // rr_ptr back at 0: req 1 beats req 3.
        cmd_arr[1] = wr_cmd(1);
        cmd_arr[3] = wr_cmd(3);
        req_vld    = 4'b1010;
        for (int t = 0; t < 20 && req_rdy == '0; t++) @(negedge pclk);
        req_vld = '0;
        check("t6_grant", req_rdy, 4'b0010);
        check("t6_grant_id", grant_id, 1);
        wait_cmd_vld("t6_wait_cmd_vld2");
        check("t6_cmd", cmd, wr_cmd(1));
        apb_slave(0, 32'h0, 1'b0);
        check("t6_rsp_vld", rsp_vld, 4'b0010);
        check("t6_rsp_err", rsp_err, 0);

        repeat (4) @(negedge pclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
